ofdm_subcarrier_scheduler: RTL and testbench

//  Tx-side sequencer between the bit FIFO and the IFFT input buffer.

---
 rtl/ofdm_tx_pkg.sv | 60 ++++++
 rtl/qam_mapper.sv | 55 +++++
 rtl/ofdm_subcarrier_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_ofdm_subcarrier_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_tx_pkg
// Shared types and constellation constants for the OFDM Tx subcarrier
// scheduler and its QAM mapper.
//   mod_order_e     : modulation order encoding (matches the 2-bit mod_order port)
//   carrier_class_e : per-carrier class (null / pilot / data)
//   sched_state_e   : scheduler FSM states
//   lvl16 / lvl64   : per-axis amplitude lookup for 16QAM / 64QAM
// ----------------------------------------------------------------------------
package ofdm_tx_pkg;

    typedef enum logic [1:0] {
        ModBpsk  = 2'd0,
        ModQpsk  = 2'd1,
        Mod16Qam = 2'd2,
        Mod64Qam = 2'd3
    } mod_order_e;

    typedef enum logic [1:0] {
        ClsNull  = 2'd0,
        ClsPilot = 2'd1,
        ClsData  = 2'd2
    } carrier_class_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSym  = 2'd1,
        StMap  = 2'd2,
        StDone = 2'd3
    } sched_state_e;

    localparam int L_BPSK  = 1039;
    localparam int L_QPSK  = 1039;
    localparam int A16     = 465;
    localparam int L_PILOT = 1039;
    localparam int L64_0   = 210;
    localparam int L64_1   = 630;
    localparam int L64_2   = 1050;
    localparam int L64_3   = 1470;

    // 16QAM axis: 0:-3A, 1:-A, 2:+3A, 3:+A (bit 1 is the sign)
    function automatic int lvl16(input logic [1:0] b);
        int mag;
        mag = b[0] ? A16 : 3 * A16;
        return b[1] ? mag : -mag;
    endfunction

    // 64QAM axis: bit 2 is the sign, bits [1:0] are Gray-coded magnitude
    function automatic int lvl64(input logic [2:0] b);
        int mag;
        case (b[1:0])
            2'b00:   mag = L64_3;
            2'b01:   mag = L64_2;
            2'b10:   mag = L64_0;
            default: mag = L64_1;
        endcase
        return b[2] ? mag : -mag;
    endfunction

endpackage

// File: rtl/qam_mapper.sv
// ----------------------------------------------------------------------------
// qam_mapper
// Combinational constellation mapper. I takes the low half of the used bits,
// Q the high half; bits above the order's width are ignored.
// Ports:
//   i_mod_order : modulation order (BPSK/QPSK/16QAM/64QAM)
//   i_bits      : LSB-aligned bit word
//   o_i, o_q    : signed two's-complement I/Q levels
// ----------------------------------------------------------------------------
module qam_mapper
    import ofdm_tx_pkg::*;
#(
    parameter int unsigned MAX_BITS = 6,
    parameter int unsigned SAMPLE_W = 12
) (
    input  mod_order_e                  i_mod_order,
    input  logic [MAX_BITS-1:0]         i_bits,
    output logic signed [SAMPLE_W-1:0]  o_i,
    output logic signed [SAMPLE_W-1:0]  o_q
);

    int w_i;
    int w_q;

    always_comb begin
        w_i = 0;
        w_q = 0;
        unique case (i_mod_order)
            ModBpsk: begin
                w_i = i_bits[0] ? L_BPSK : -L_BPSK;
                w_q = 0;
            end
            ModQpsk: begin
                w_i = i_bits[0] ? L_QPSK : -L_QPSK;
                w_q = i_bits[1] ? L_QPSK : -L_QPSK;
            end
            Mod16Qam: begin
                w_i = lvl16(i_bits[1:0]);
                w_q = lvl16(i_bits[3:2]);
            end
            Mod64Qam: begin
                w_i = lvl64(i_bits[2:0]);
                w_q = lvl64(i_bits[5:3]);
            end
            default: begin
                w_i = 0;
                w_q = 0;
            end
        endcase
    end

    assign o_i = SAMPLE_W'(w_i);
    assign o_q = SAMPLE_W'(w_q);

endmodule

// File: rtl/ofdm_subcarrier_scheduler.sv
// ----------------------------------------------------------------------------
// ofdm_subcarrier_scheduler
// Tx sequencer between the bit FIFO and the IFFT input buffer. For each OFDM
// symbol of a frame it walks carriers 0..N_FFT-1, classifies each as null,
// pilot or data, and emits one registered (sub_i, sub_q, sub_idx) sample per
// carrier on a valid/ready stream. Data carriers consume one bit word each.
// Build option: define OFDM_PILOT_EN to enable pilot carriers (every
// 2**PILOT_SHIFT carriers, consuming no bits); otherwise they carry data.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : begin frame (ignored while busy)
//   i_num_sym        : symbols per frame, sampled on start (0 means 1)
//   i_mod_order      : modulation order, latched at each symbol start
//   i_bits_data/valid, o_bits_ready : bit word input handshake
//   o_sub_i/q/idx, o_sub_valid, i_sub_ready, o_sym_last : sample stream
//   o_busy           : frame in progress
//   o_done           : one-cycle pulse after the frame's last sample is accepted
// ----------------------------------------------------------------------------
module ofdm_subcarrier_scheduler
    import ofdm_tx_pkg::*;
#(
    parameter int unsigned N_FFT       = 1024,
    parameter int unsigned N_USED      = 800,
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned MAX_BITS    = 6,
    parameter int unsigned SYM_CNT_W   = 8,
    parameter int unsigned PILOT_SHIFT = 3,
    localparam int unsigned IDX_W      = $clog2(N_FFT)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [SYM_CNT_W-1:0]        i_num_sym,
    input  logic [1:0]                  i_mod_order,
    input  logic [MAX_BITS-1:0]         i_bits_data,
    input  logic                        i_bits_valid,
    output logic                        o_bits_ready,
    output logic signed [SAMPLE_W-1:0]  o_sub_i,
    output logic signed [SAMPLE_W-1:0]  o_sub_q,
    output logic [IDX_W-1:0]            o_sub_idx,
    output logic                        o_sub_valid,
    input  logic                        i_sub_ready,
    output logic                        o_sym_last,
    output logic                        o_busy,
    output logic                        o_done
);

`ifdef OFDM_PILOT_EN
    localparam bit PilotEn = 1'b1;
`else
    localparam bit PilotEn = 1'b0;
`endif

    localparam logic [IDX_W-1:0] HalfUsed = IDX_W'(N_USED / 2);
    localparam logic [IDX_W-1:0] GuardHi  = IDX_W'(N_FFT - N_USED / 2);
    localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(N_FFT - 1);

    sched_state_e               r_state;
    sched_state_e               w_state_d;

    mod_order_e                 r_mod;
    logic [SYM_CNT_W-1:0]       r_num_sym;
    logic [SYM_CNT_W-1:0]       r_sym_cnt;
    logic [IDX_W-1:0]           r_idx;
    // Set once carrier N_FFT-1 is in the output register; blocks further loads
    // until that sample is accepted and the next symbol starts.
    logic                       r_issued_all;

    logic signed [SAMPLE_W-1:0] r_sub_i;
    logic signed [SAMPLE_W-1:0] r_sub_q;
    logic [IDX_W-1:0]           r_sub_idx;
    logic                       r_sub_valid;
    logic                       r_sym_last;

    carrier_class_e             w_class;
    logic                       w_null;
    logic                       w_pilot_slot;
    logic                       w_slot_free;
    logic                       w_gen;
    logic                       w_bits_ready;
    logic                       w_load;
    logic                       w_idx_last;
    logic                       w_last_accept;
    logic                       w_last_sym;
    logic signed [SAMPLE_W-1:0] w_map_i;
    logic signed [SAMPLE_W-1:0] w_map_q;
    logic signed [SAMPLE_W-1:0] w_sel_i;
    logic signed [SAMPLE_W-1:0] w_sel_q;

    // ------------------------------------------------------------------------
    // Carrier classifier
    // ------------------------------------------------------------------------
    assign w_null       = (r_idx == '0) || ((r_idx > HalfUsed) && (r_idx < GuardHi));
    assign w_pilot_slot = (r_idx[PILOT_SHIFT-1:0] == '0);

    always_comb begin
        w_class = ClsData;
        if (w_null) begin
            w_class = ClsNull;
        end else if (PilotEn && w_pilot_slot) begin
            w_class = ClsPilot;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake / load control
    // ------------------------------------------------------------------------
    assign w_slot_free   = !r_sub_valid || i_sub_ready;
    assign w_gen         = (r_state == StMap) && !r_issued_all;
    assign w_bits_ready  = w_gen && (w_class == ClsData) && w_slot_free;
    assign w_load        = w_gen && w_slot_free && ((w_class != ClsData) || i_bits_valid);
    assign w_idx_last    = (r_idx == IdxLast);
    assign w_last_accept = r_sub_valid && i_sub_ready && r_sym_last;
    assign w_last_sym    = (r_sym_cnt == r_num_sym - 1'b1);

    qam_mapper #(
        .MAX_BITS (MAX_BITS),
        .SAMPLE_W (SAMPLE_W)
    ) u_qam_mapper (
        .i_mod_order (r_mod),
        .i_bits      (i_bits_data),
        .o_i         (w_map_i),
        .o_q         (w_map_q)
    );

    always_comb begin
        w_sel_i = '0;
        w_sel_q = '0;
        if (w_class == ClsData) begin
            w_sel_i = w_map_i;
            w_sel_q = w_map_q;
        end else if (w_class == ClsPilot) begin
            w_sel_i = SAMPLE_W'(L_PILOT);
            w_sel_q = '0;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StSym;
                end
            end
            StSym: begin
                w_state_d = StMap;
            end
            StMap: begin
                if (w_last_accept) begin
                    w_state_d = w_last_sym ? StDone : StSym;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters, latched configuration and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mod        <= ModBpsk;
            r_num_sym    <= '0;
            r_sym_cnt    <= '0;
            r_idx        <= '0;
            r_issued_all <= 1'b0;
            r_sub_i      <= '0;
            r_sub_q      <= '0;
            r_sub_idx    <= '0;
            r_sub_valid  <= 1'b0;
            r_sym_last   <= 1'b0;
        end else begin
            if ((r_state == StIdle) && i_start) begin
                r_num_sym <= (i_num_sym == '0) ? SYM_CNT_W'(1) : i_num_sym;
                r_sym_cnt <= '0;
            end

            if (r_state == StSym) begin
                r_mod        <= mod_order_e'(i_mod_order);
                r_idx        <= '0;
                r_issued_all <= 1'b0;
            end

            if (w_load) begin
                r_sub_i     <= w_sel_i;
                r_sub_q     <= w_sel_q;
                r_sub_idx   <= r_idx;
                r_sub_valid <= 1'b1;
                r_sym_last  <= w_idx_last;
                r_idx       <= r_idx + 1'b1;
                if (w_idx_last) begin
                    r_issued_all <= 1'b1;
                end
            end else if (i_sub_ready) begin
                r_sub_valid <= 1'b0;
                r_sym_last  <= 1'b0;
            end

            if ((r_state == StMap) && w_last_accept && !w_last_sym) begin
                r_sym_cnt <= r_sym_cnt + 1'b1;
            end
        end
    end

    assign o_bits_ready = w_bits_ready;
    assign o_sub_i      = r_sub_i;
    assign o_sub_q      = r_sub_q;
    assign o_sub_idx    = r_sub_idx;
    assign o_sub_valid  = r_sub_valid;
    assign o_sym_last   = r_sym_last;
    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_ofdm_subcarrier_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ofdm_subcarrier_scheduler
// Scoreboard bench: each frame's expected carrier stream is queued before the
// frame starts; a negedge monitor pops and compares every accepted sample.
// Directed checks cover reset, abort, back-pressure, bit starvation, mid-frame
// mod_order change, start-while-busy and num_sym=0.
// ----------------------------------------------------------------------------
module tb_ofdm_subcarrier_scheduler;

    localparam int NFFT  = 1024;
    localparam int NUSED = 800;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         num_sym;
    logic [1:0]         mod_order;
    logic [5:0]         bits_data;
    logic               bits_valid;
    logic               bits_ready;
    logic signed [11:0] sub_i;
    logic signed [11:0] sub_q;
    logic [9:0]         sub_idx;
    logic               sub_valid;
    logic               sub_ready;
    logic               sym_last;
    logic               busy;
    logic               done;

    typedef struct {
        int i;
        int q;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   word_n   = 0;
    bit   hs_bits  = 1'b0;
    bit   const_en = 1'b0;
    logic [5:0] const_word = 6'd0;

    int L16[4] = '{-1395, -465, 1395, 465};
    int L64[8] = '{-1470, -1050, -210, -630, 1470, 1050, 210, 630};

    always #5 clk = ~clk;

    ofdm_subcarrier_scheduler u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_sym    (num_sym),
        .i_mod_order  (mod_order),
        .i_bits_data  (bits_data),
        .i_bits_valid (bits_valid),
        .o_bits_ready (bits_ready),
        .o_sub_i      (sub_i),
        .o_sub_q      (sub_q),
        .o_sub_idx    (sub_idx),
        .o_sub_valid  (sub_valid),
        .i_sub_ready  (sub_ready),
        .o_sym_last   (sym_last),
        .o_busy       (busy),
        .o_done       (done)
    );

    // Word n of the bit source; varies so lost/duplicated words show up.
    function automatic logic [5:0] wval(input int n);
        int t;
        t = n * 7 + 3;
        return t[5:0];
    endfunction

    function automatic bit is_null(input int k);
        return (k == 0) || ((k > NUSED / 2) && (k < NFFT - NUSED / 2));
    endfunction

    function automatic bit is_pilot(input int k);
`ifdef OFDM_PILOT_EN
        return !is_null(k) && ((k % 8) == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int data_carriers();
`ifdef OFDM_PILOT_EN
        return 700;
`else
        return 800;
`endif
    endfunction

    task automatic push_symbol(input int mod, inout int wn);
        exp_t e;
        logic [5:0] w;
        for (int k = 0; k < NFFT; k++) begin
            e.idx  = k;
            e.last = (k == NFFT - 1);
            e.i    = 0;
            e.q    = 0;
            if (is_null(k)) begin
                e.i = 0;
                e.q = 0;
            end else if (is_pilot(k)) begin
                e.i = 1039;
                e.q = 0;
            end else begin
                w  = wval(wn);
                wn = wn + 1;
                case (mod)
                    0: begin
                        e.i = w[0] ? 1039 : -1039;
                        e.q = 0;
                    end
                    1: begin
                        e.i = w[0] ? 1039 : -1039;
                        e.q = w[1] ? 1039 : -1039;
                    end
                    2: begin
                        e.i = L16[w[1:0]];
                        e.q = L16[w[3:2]];
                    end
                    default: begin
                        e.i = L64[w[2:0]];
                        e.q = L64[w[5:3]];
                    end
                endcase
            end
            exp_q.push_back(e);
        end
    endtask

    // 64QAM with the constant word 6'b000_100: I=+1470, Q=-1470 on every data carrier.
    task automatic push_const_64();
        exp_t e;
        for (int k = 0; k < NFFT; k++) begin
            e.idx  = k;
            e.last = (k == NFFT - 1);
            if (is_null(k)) begin
                e.i = 0;
                e.q = 0;
            end else if (is_pilot(k)) begin
                e.i = 1039;
                e.q = 0;
            end else begin
                e.i = 1470;
                e.q = -1470;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic start_frame(input int n, input int mod);
        @(posedge clk);
        #1;
        num_sym   = 8'(n);
        mod_order = 2'(mod);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  c0;
        bit  seen;
        c0   = done_cnt;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_cnt != c0) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic wait_idx(input string name, input int target, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (sub_valid && (int'(sub_idx) == target)) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    // Monitor: a sample visible with sub_ready high at negedge is accepted at
    // the next posedge (inputs only change just after posedge).
    always @(negedge clk) begin
        exp_t e;
        hs_bits = bits_valid && bits_ready;
        if (done) done_cnt++;
        if (sub_valid && sub_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got idx %0d i %0d q %0d, expected no sample",
                         sub_idx, sub_i, sub_q);
            end else begin
                e = exp_q.pop_front();
                if (int'(sub_i) != e.i || int'(sub_q) != e.q || int'(sub_idx) != e.idx ||
                    sym_last != e.last) begin
                    errors++;
                    $display("FAIL sb_sample: got idx %0d i %0d q %0d last %0d, expected idx %0d i %0d q %0d last %0d",
                             sub_idx, sub_i, sub_q, sym_last, e.idx, e.i, e.q, e.last);
                end
            end
        end
    end

    // Bit source: advances to the next word after each accepted handshake.
    always @(posedge clk) begin
        #1;
        if (hs_bits) word_n++;
        bits_data = const_en ? const_word : wval(word_n);
    end

    initial begin
        int   wn;
        int   base;
        int   dc;
        int   saved;
        exp_t h;

        rst        = 1'b1;
        start      = 1'b0;
        num_sym    = 8'd0;
        mod_order  = 2'd0;
        bits_valid = 1'b0;
        sub_ready  = 1'b1;
        bits_data  = 6'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", int'({busy, done, sub_valid, sym_last, bits_ready}), 0);
        check("reset_data", int'(|{sub_i, sub_q, sub_idx}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-MAP aborts the frame with no done pulse.
        wn = word_n;
        push_symbol(3, wn);
        bits_valid = 1'b1;
        start_frame(1, 3);
        wait_idx("abort_reach_37", 37, 200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dc  = done_cnt;
        @(posedge clk);
        @(negedge clk);
        check("abort_ctrl", int'({busy, done, sub_valid, sym_last, bits_ready}), 0);
        check("abort_data", int'(|{sub_i, sub_q, sub_idx}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);
        check("abort_idle", int'(busy), 0);

        // Constant-word 64QAM symbol.
        const_en   = 1'b1;
        const_word = 6'b000_100;
        repeat (2) @(posedge clk);
        base = word_n;
        dc   = done_cnt;
        push_const_64();
        start_frame(1, 3);
        wait_done("c64_done", 3000);
        repeat (3) @(negedge clk);
        check("c64_words", word_n - base, data_carriers());
        check("c64_done_once", done_cnt - dc, 1);
        check("c64_drained", exp_q.size(), 0);
        const_en = 1'b0;
        repeat (2) @(posedge clk);

        // 16QAM symbol with back-pressure at idx 3 and bit starvation at idx 5.
        wn = word_n;
        dc = done_cnt;
        push_symbol(2, wn);
        start_frame(1, 2);
        wait_idx("bp_reach_2", 2, 100);
        @(posedge clk);
        #1;
        sub_ready = 1'b0;
        h.i = 0;
        h.q = 0;
        if (exp_q.size() > 0) h = exp_q[0];
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(sub_valid), 1);
            check("bp_hold_idx", int'(sub_idx), 3);
            check("bp_hold_i", int'(sub_i), h.i);
            check("bp_hold_q", int'(sub_q), h.q);
            check("bp_bits_ready", int'(bits_ready), 0);
        end
        @(posedge clk);
        #1;
        sub_ready = 1'b1;
        @(posedge clk);
        #1;
        bits_valid = 1'b0;
        @(negedge clk);
        saved = word_n;
        repeat (9) @(negedge clk);
        check("starve_valid_low", int'(sub_valid), 0);
        check("starve_bits_ready", int'(bits_ready), 1);
        check("starve_no_words", word_n - saved, 0);
        @(posedge clk);
        #1;
        bits_valid = 1'b1;
        wait_done("bp_done", 3000);
        repeat (3) @(negedge clk);
        check("bp_done_once", done_cnt - dc, 1);
        check("bp_drained", exp_q.size(), 0);

        // Two symbols; mod_order 3->0 during symbol 0; start pulsed while busy.
        wn = word_n;
        dc = done_cnt;
        push_symbol(3, wn);
        push_symbol(0, wn);
        start_frame(2, 3);
        repeat (20) @(posedge clk);
        #1;
        mod_order = 2'd0;
        num_sym   = 8'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("two_sym_done", 5000);
        repeat (5) @(negedge clk);
        check("two_sym_done_once", done_cnt - dc, 1);
        check("two_sym_idle", int'(busy), 0);
        check("two_sym_drained", exp_q.size(), 0);

        // num_sym = 0 behaves as one symbol.
        wn = word_n;
        dc = done_cnt;
        push_symbol(1, wn);
        start_frame(0, 1);
        wait_done("zero_sym_done", 3000);
        repeat (5) @(negedge clk);
        check("zero_sym_done_once", done_cnt - dc, 1);
        check("zero_sym_idle", int'(busy), 0);
        check("zero_sym_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
